// File: rtl/pixel_writer.sv
// Pixel stream sink: clips painter coordinates, buffers linear framebuffer writes in a
// small FIFO and drains them to a ready-gated BRAM write port; also runs a full-frame clear.
module pixel_writer #(
  parameter int H_RES       = 1280,
  parameter int V_RES       = 720,
  parameter int ADDR_WIDTH  = 20,
  parameter int COLOR_WIDTH = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   data_valid_in,
  input  logic [COLOR_WIDTH-1:0] color_in,
  input  logic                   clear_in,
  input  logic [COLOR_WIDTH-1:0] clear_color_in,
  input  logic                   mem_ready_in,
  output logic [ADDR_WIDTH-1:0]  mem_addr_out,
  output logic [COLOR_WIDTH-1:0] mem_data_out,
  output logic                   mem_we_out,
  output logic                   busy_out,
  output logic                   overflow_out,
  output logic [15:0]            dropped_count_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = ADDR_WIDTH + COLOR_WIDTH;
  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [9:0] V_LIM = 10'(V_RES);
  localparam logic [ADDR_WIDTH:0] CLEAR_END = (ADDR_WIDTH+1)'(H_RES * V_RES);
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t                 state;
  logic                   stage_valid;
  logic [ENTRY_W-1:0]     stage_entry;
  logic [ENTRY_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         fifo_count;
  logic [ADDR_WIDTH:0]    clear_addr;
  logic [COLOR_WIDTH-1:0] clear_color;

  logic                  in_frame;
  logic [ADDR_WIDTH-1:0] pixel_addr;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  push;
  logic                  stage_free;
  logic                  capture;
  logic                  lost;
  logic                  drop;

  always_comb begin
    in_frame   = (hcount_in < H_LIM) && (vcount_in < V_LIM);
    pixel_addr = ADDR_WIDTH'(vcount_in) * ADDR_WIDTH'(H_RES) + ADDR_WIDTH'(hcount_in);
    fifo_empty = (fifo_count == '0);
    fifo_full  = (fifo_count == FIFO_FULL);
    pop        = !fifo_empty && mem_ready_in && (state != CLEAR);
    // The stage register only advances when the FIFO can take it, so a full FIFO
    // parks one extra pixel in the stage and sheds the newer arrivals instead.
    push       = stage_valid && (!fifo_full || pop);
    stage_free = !stage_valid || push;
    capture    = (state == IDLE) && data_valid_in && in_frame && stage_free;
    lost       = (state == IDLE) && data_valid_in && in_frame && !stage_free;
    drop       = data_valid_in && ((state != IDLE) || !in_frame || !stage_free);
  end

  assign busy_out = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= stage_entry;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state             <= IDLE;
      stage_valid       <= 1'b0;
      stage_entry       <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_count        <= '0;
      clear_addr        <= '0;
      clear_color       <= '0;
      mem_addr_out      <= '0;
      mem_data_out      <= '0;
      mem_we_out        <= 1'b0;
      overflow_out      <= 1'b0;
      dropped_count_out <= '0;
    end else begin
      if (capture) begin
        stage_valid <= 1'b1;
        stage_entry <= {pixel_addr, color_in};
      end else if (push) begin
        stage_valid <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (lost) overflow_out <= 1'b1;
      if (drop && dropped_count_out != 16'hFFFF) dropped_count_out <= dropped_count_out + 1'b1;

      mem_we_out <= 1'b0;
      if (state == CLEAR) begin
        if (clear_addr != CLEAR_END && mem_ready_in) begin
          mem_addr_out <= clear_addr[ADDR_WIDTH-1:0];
          mem_data_out <= clear_color;
          mem_we_out   <= 1'b1;
          clear_addr   <= clear_addr + 1'b1;
        end
      end else if (pop) begin
        {mem_addr_out, mem_data_out} <= fifo_mem[rd_ptr];
        mem_we_out <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (clear_in) begin
            clear_color <= clear_color_in;
            clear_addr  <= '0;
            if (!stage_valid && fifo_empty && !capture) state <= CLEAR;
            else                                        state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!stage_valid && fifo_empty) state <= CLEAR;
        end
        CLEAR: begin
          // One idle cycle past the last address keeps busy high alongside the final strobe.
          if (clear_addr == CLEAR_END) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer on a 1280x4 frame so the clear sweep stays short;
// a negedge scoreboard checks every write strobe against an expected queue.
module tb_pixel_writer;

  localparam int H_RES = 1280;
  localparam int V_RES = 4;
  localparam int AW = 20;
  localparam int CW = 16;
  localparam int FRAME = H_RES * V_RES;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic [10:0]   hcount_in = '0;
  logic [9:0]    vcount_in = '0;
  logic          data_valid_in = 1'b0;
  logic [CW-1:0] color_in = '0;
  logic          clear_in = 1'b0;
  logic [CW-1:0] clear_color_in = '0;
  logic          mem_ready_in = 1'b0;
  logic [AW-1:0] mem_addr_out;
  logic [CW-1:0] mem_data_out;
  logic          mem_we_out;
  logic          busy_out;
  logic          overflow_out;
  logic [15:0]   dropped_count_out;

  int checks = 0;
  int errors = 0;
  int n_writes = 0;
  logic ready_seen = 1'b0;
  logic last_we_busy = 1'b0;
  logic [AW+CW-1:0] exp_q[$];

  pixel_writer #(
    .H_RES(H_RES), .V_RES(V_RES), .ADDR_WIDTH(AW), .COLOR_WIDTH(CW), .FIFO_DEPTH(8)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .data_valid_in(data_valid_in),
    .color_in(color_in), .clear_in(clear_in), .clear_color_in(clear_color_in),
    .mem_ready_in(mem_ready_in), .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .mem_we_out(mem_we_out), .busy_out(busy_out), .overflow_out(overflow_out),
    .dropped_count_out(dropped_count_out)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [AW+CW-1:0] obs, input logic [AW+CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW+CW-1:0] entry(input int addr, input logic [CW-1:0] c);
    return {AW'(addr), c};
  endfunction

  // Drivers: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_pixel(input int h, input int v, input logic [CW-1:0] c);
    hcount_in     = 11'(h);
    vcount_in     = 10'(v);
    color_in      = c;
    data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
  endtask

  // Scoreboard: every strobe must follow a ready-high edge and match the queue head.
  always @(negedge clk_in) begin
    if (mem_we_out) begin
      n_writes++;
      last_we_busy = busy_out;
      chk("write_needs_ready", {35'd0, ready_seen}, 36'd1);
      if (exp_q.size() == 0) chk("unexpected_write", {35'd0, mem_we_out}, 36'd0);
      else chk("write_entry", {mem_addr_out, mem_data_out}, exp_q.pop_front());
    end
    ready_seen = mem_ready_in;
  end

  initial begin
    // Reset
    repeat (3) tick();
    chk("rst_we", {35'd0, mem_we_out}, 36'd0);
    chk("rst_addr", {16'd0, mem_addr_out}, 36'd0);
    chk("rst_data", {20'd0, mem_data_out}, 36'd0);
    chk("rst_busy", {35'd0, busy_out}, 36'd0);
    chk("rst_overflow", {35'd0, overflow_out}, 36'd0);
    chk("rst_dropped", {20'd0, dropped_count_out}, 36'd0);
    rst_in = 1'b1;
    tick();

    // Single pixel: strobe three cycles after sampling
    mem_ready_in = 1'b1;
    exp_q.push_back(entry(2570, 16'hF800));
    send_pixel(10, 2, 16'hF800);
    chk("lat_c1_we", {35'd0, mem_we_out}, 36'd0);
    tick();
    chk("lat_c2_we", {35'd0, mem_we_out}, 36'd0);
    tick();
    chk("lat_c3_we", {35'd0, mem_we_out}, 36'd1);
    chk("lat_c3_addr", {16'd0, mem_addr_out}, 36'd2570);
    chk("lat_c3_data", {20'd0, mem_data_out}, 36'hF800);
    chk("single_overflow", {35'd0, overflow_out}, 36'd0);
    tick();
    chk("single_pulse_we", {35'd0, mem_we_out}, 36'd0);

    // Clipping, including the first row past the frame
    send_pixel(1280, 0, 16'h1111);
    send_pixel(5, 720, 16'h2222);
    send_pixel(2047, 1023, 16'h3333);
    send_pixel(0, V_RES, 16'h4444);
    repeat (5) tick();
    chk("clip_dropped", {20'd0, dropped_count_out}, 36'd4);
    chk("clip_no_write", 36'(n_writes), 36'd1);

    // Backpressure: 12 pixels, 9 retained, 3 lost
    mem_ready_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i < 9) exp_q.push_back(entry((i % 4) * H_RES + 1279 - i, 16'h0100 + 16'(i)));
      send_pixel(1279 - i, i % 4, 16'h0100 + 16'(i));
    end
    repeat (3) tick();
    chk("ovf_flag", {35'd0, overflow_out}, 36'd1);
    chk("ovf_dropped", {20'd0, dropped_count_out}, 36'd7);
    chk("ovf_no_write", 36'(n_writes), 36'd1);
    mem_ready_in = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
    repeat (3) tick();
    chk("ovf_queue_empty", 36'(exp_q.size()), 36'd0);
    chk("ovf_writes", 36'(n_writes), 36'd10);
    chk("ovf_sticky", {35'd0, overflow_out}, 36'd1);

    // Clear with two pixels queued and a toggling ready
    mem_ready_in = 1'b0;
    exp_q.push_back(entry(3, 16'hAAAA));
    exp_q.push_back(entry(H_RES + 4, 16'h5555));
    send_pixel(3, 0, 16'hAAAA);
    send_pixel(4, 1, 16'h5555);
    clear_in = 1'b1;
    clear_color_in = 16'h0000;
    tick();
    clear_in = 1'b0;
    clear_color_in = 16'hFFFF;
    for (int a = 0; a < FRAME; a++) exp_q.push_back(entry(a, 16'h0000));
    for (int cyc = 0; cyc < 20000 && exp_q.size() != 0; cyc++) begin
      mem_ready_in   = (cyc % 3 != 2);
      clear_in       = (cyc == 100);
      clear_color_in = (cyc == 100) ? 16'h1234 : 16'hFFFF;
      data_valid_in  = (cyc >= 200 && cyc <= 202);
      hcount_in      = 11'(cyc);
      vcount_in      = 10'd1;
      if (cyc == 50) chk("clear_busy_mid", {35'd0, busy_out}, 36'd1);
      tick();
    end
    clear_in = 1'b0;
    data_valid_in = 1'b0;
    chk("clear_queue_empty", 36'(exp_q.size()), 36'd0);
    chk("clear_busy_last_we", {35'd0, last_we_busy}, 36'd1);
    chk("clear_busy_after", {35'd0, busy_out}, 36'd0);
    chk("clear_dropped", {20'd0, dropped_count_out}, 36'd10);
    chk("clear_writes", 36'(n_writes), 36'(12 + FRAME));
    repeat (3) tick();
    chk("clear_quiet_after", 36'(n_writes), 36'(12 + FRAME));

    // Asynchronous reset mid-sweep at address 1000
    mem_ready_in = 1'b1;
    clear_in = 1'b1;
    clear_color_in = 16'hABCD;
    for (int a = 0; a <= 1000; a++) exp_q.push_back(entry(a, 16'hABCD));
    tick();
    clear_in = 1'b0;
    for (int k = 0; k < 5000 && exp_q.size() != 0; k++) begin
      @(negedge clk_in);
      #2;
    end
    chk("mid_clear_addr", {16'd0, mem_addr_out}, 36'd1000);
    chk("mid_clear_we", {35'd0, mem_we_out}, 36'd1);
    rst_in = 1'b0;
    #1;
    chk("async_rst_we", {35'd0, mem_we_out}, 36'd0);
    chk("async_rst_busy", {35'd0, busy_out}, 36'd0);
    chk("async_rst_addr", {16'd0, mem_addr_out}, 36'd0);
    chk("async_rst_data", {20'd0, mem_data_out}, 36'd0);
    chk("async_rst_overflow", {35'd0, overflow_out}, 36'd0);
    chk("async_rst_dropped", {20'd0, dropped_count_out}, 36'd0);
    exp_q.delete();
    repeat (2) tick();
    rst_in = 1'b1;
    tick();
    chk("post_rst_busy", {35'd0, busy_out}, 36'd0);
    exp_q.push_back(entry(3 * H_RES, 16'h7777));
    send_pixel(0, 3, 16'h7777);
    repeat (4) tick();
    chk("post_rst_pixel", 36'(exp_q.size()), 36'd0);
    chk("post_rst_dropped", {20'd0, dropped_count_out}, 36'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
- Consumer end of the painter pixel stream. Accepts (hcount, vcount, valid) pixel coordinates as produced by the circle painter.
- Clips each pixel to the visible frame, converts it to a linear framebuffer address, and buffers it in a small FIFO.
- Issues single-cycle writes to the framebuffer BRAM port under a ready signal.
- Also provides a full-frame clear sweep. Sits between the painter and the framebuffer.

Parameters:
- H_RES, 1280, visible pixels per line
- V_RES, 720, visible lines per frame
- ADDR_WIDTH, 20, framebuffer address width; must satisfy 2^ADDR_WIDTH >= H_RES*V_RES
- COLOR_WIDTH, 16, pixel data width
- FIFO_DEPTH, 8, pixel FIFO entries, power of two

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- hcount_in  input  11  pixel x coordinate (unsigned)
- vcount_in  input  10  pixel y coordinate (unsigned)
- data_valid_in  input  1  pixel coordinate valid this cycle; no backpressure upstream
- color_in  input  COLOR_WIDTH  colour for the pixel on this cycle
- clear_in  input  1  single-cycle request to clear the whole frame
- clear_color_in  input  COLOR_WIDTH  fill colour, sampled with clear_in
- mem_ready_in  input  1  framebuffer write port can accept a write this cycle
- mem_addr_out  output  ADDR_WIDTH  write address
- mem_data_out  output  COLOR_WIDTH  write data
- mem_we_out  output  1  write strobe, one cycle per write
- busy_out  output  1  high whenever state is not IDLE
- overflow_out  output  1  sticky: a pixel was lost to FIFO full
- dropped_count_out  output  16  saturating count of pixels not written (clipped, overflowed or ignored)

Behaviour:
- Reset (rst_in low, asynchronous):
  - All outputs are 0 and the FIFO is empty.
  - State is IDLE; the stage register is invalid.
  - Reset mid-clear or mid-drain aborts immediately; no further writes are issued.
- States:
  - IDLE: accepts pixels.
  - DRAIN: FIFO still non-empty after a clear request.
  - CLEAR: clear sweep in progress.
- Input stage (IDLE only):
  - Pixels are sampled on data_valid_in.
  - Clip: if hcount_in >= H_RES or vcount_in >= V_RES, the pixel is dropped and dropped_count_out increments. This also catches coordinates that wrapped negative upstream.
  - Otherwise the stage register captures addr = vcount_in*H_RES + hcount_in (exact, ADDR_WIDTH bits) and color_in.
- FIFO push: the stage register is written into the FIFO on the following edge.
  - If the FIFO is full and no pop occurs that cycle, the pixel is lost: overflow_out sets (sticky until reset) and dropped_count_out increments.
  - Simultaneous push and pop on a full FIFO succeeds with no loss.
- Write port:
  - When the FIFO is non-empty and mem_ready_in is high, one entry is popped. On the next edge mem_addr_out/mem_data_out are registered with that entry and mem_we_out is set high for exactly one cycle.
  - If mem_ready_in is low, no pop occurs and mem_we_out is 0.
  - mem_addr_out/mem_data_out hold their last value when mem_we_out is 0.
  - A strobed write is considered accepted.
- Latency: with an empty FIFO and mem_ready_in held high, a pixel sampled in cycle 0 produces mem_we_out high in cycle 3. Sustained throughput is 1 pixel/cycle.
- Pixel order is preserved.
- clear_in:
  - Honoured only in IDLE; ignored in DRAIN and CLEAR.
  - On acceptance, latch clear_color_in and go to DRAIN; go directly to CLEAR if the FIFO and stage register are both empty.
  - A pixel that is valid in the same cycle as an accepted clear_in is still accepted and is written before the clear.
- DRAIN: no new pixels are accepted; any that arrive are counted in dropped_count_out. The FIFO empties normally, then the state goes to CLEAR.
- CLEAR:
  - Issues writes to addresses 0 .. H_RES*V_RES-1 in ascending order with the latched colour.
  - Advances the address only on cycles where mem_ready_in is high.
  - Incoming pixels are ignored and counted.
  - After the write to the last address, the state returns to IDLE; busy_out falls on the cycle after the last mem_we_out.
- dropped_count_out saturates at 16'hFFFF.

Test Plan:
- Single pixel: h=10, v=2, color=16'hF800, mem_ready_in=1 -> one mem_we_out pulse 3 cycles later, addr=2570, data=16'hF800; overflow_out stays 0.
- Clipping: h=1280,v=0 then h=5,v=720 then h=2047,v=1023 -> no mem_we_out; dropped_count_out=3.
- Backpressure and overflow: mem_ready_in=0, 12 consecutive valid in-frame pixels -> FIFO_DEPTH+1=9 retained (8 in the FIFO plus the stage register), overflow_out=1, dropped_count_out=3. Then mem_ready_in=1 -> exactly 9 writes, in input order.
- Clear with toggling ready: clear_in with clear_color_in=16'h0000 while 2 pixels are queued -> 2 pixel writes first, then 921600 writes, addr 0..921599, with addr advancing only on ready-high cycles; busy_out high throughout, low afterwards.
- clear_in during CLEAR and pixels during CLEAR -> clear_in ignored; each pixel increments dropped_count_out; sweep unaffected.
- rst_in low asynchronously mid-CLEAR at addr 1000 -> mem_we_out, busy_out and all outputs go to 0 without waiting for a clock edge; after release the block is in IDLE and accepts a pixel normally.
